// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an I-cache and a D-cache.
// Read misses fetch an 8-word block. D-side writes store a single word.
// Build option ARB_ROUND_ROBIN_EN: simultaneous requests alternate between
// the two requesters. Without it the D-cache always wins a contested grant.

module mem_arbiter #(
  parameter int MEM_LAT     = 4,
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_req,
  input  logic [15:0] icache_addr,
  input  logic        dcache_req,
  input  logic [15:0] dcache_addr,
  input  logic        dcache_wr,
  input  logic [15:0] dcache_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [15:0] mem_addr,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        ifill_we,
  output logic        dfill_we,
  output logic        idone,
  output logic        ddone,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  localparam logic [2:0] LAST_WORD = 3'(BLOCK_WORDS - 1);

  // The block counters are 3 bits wide, so only 8-word blocks work.
  // Read data is tracked by mem_rvalid alone, so the latency must only be positive.
  if (MEM_LAT < 1 || BLOCK_WORDS != 8) begin : g_bad_config
    $error("mem_arbiter: unsupported MEM_LAT/BLOCK_WORDS");
  end

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        owner_q, owner_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  rv_cnt_q, rv_cnt_d;
  logic        grant_d;
  logic        rv_take;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_d_q, last_d_d;
`endif

  // A read word counts only while a fill is in progress.
  // This also ignores stray strobes that arrive after the 8th word.
  assign rv_take = mem_rvalid && (state_q == ISSUE || state_q == DRAIN);

  // State register. Reset abandons any transaction that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      owner_q     <= 1'b0;
      issue_cnt_q <= '0;
      rv_cnt_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      owner_q     <= owner_d;
      issue_cnt_q <= issue_cnt_d;
      rv_cnt_q    <= rv_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  // Arbitration, transaction sequencing, and the word counters.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    owner_d     = owner_q;
    issue_cnt_d = issue_cnt_q;
    rv_cnt_d    = rv_cnt_q;
    grant_d     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d    = last_d_q;
    if (icache_req && dcache_req) grant_d = !last_d_q;
    else                          grant_d = dcache_req;
`else
    grant_d     = dcache_req;
`endif
    case (state_q)
      IDLE: begin
        if (icache_req || dcache_req) begin
          owner_d     = grant_d;
          addr_d      = grant_d ? dcache_addr : icache_addr;
          issue_cnt_d = '0;
          rv_cnt_d    = '0;
          state_d     = (grant_d && dcache_wr) ? WRITE : ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d    = grant_d;
`endif
        end
      end
      ISSUE: begin
        issue_cnt_d = issue_cnt_q + 3'd1;
        if (rv_take) rv_cnt_d = rv_cnt_q + 3'd1;
        if (rv_take && rv_cnt_q == LAST_WORD)  state_d = DONE;
        else if (issue_cnt_q == LAST_WORD)     state_d = DRAIN;
      end
      DRAIN: begin
        if (rv_take) begin
          rv_cnt_d = rv_cnt_q + 3'd1;
          if (rv_cnt_q == LAST_WORD) state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory command, fill port, and done strobes. All of them are held at 0 while reset is asserted.
  always_comb begin
    mem_addr   = '0;
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = '0;
    fill_data  = '0;
    fill_word  = '0;
    ifill_we   = 1'b0;
    dfill_we   = 1'b0;
    idone      = 1'b0;
    ddone      = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      busy = (state_q != IDLE);
      case (state_q)
        ISSUE: begin
          mem_enable = 1'b1;
          mem_addr   = (addr_q & 16'hFFF0) + {12'd0, issue_cnt_q, 1'b0};
        end
        WRITE: begin
          mem_enable = 1'b1;
          mem_wr     = 1'b1;
          mem_addr   = addr_q & 16'hFFFE;
          mem_wdata  = dcache_wdata;
        end
        DONE: begin
          idone = !owner_q;
          ddone = owner_q;
        end
        default: ;
      endcase
      if (rv_take) begin
        fill_data = mem_rdata;
        fill_word = rv_cnt_q;
        ifill_we  = !owner_q;
        dfill_we  = owner_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// It uses a vector table, hand-written corner sequences, and random transactions.
// The memory model and the expected results are computed inside the bench.
// Define ARB_ROUND_ROBIN_EN here too when the RTL is built with that option.

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_req, dcache_req, dcache_wr, mem_rvalid;
  logic [15:0] icache_addr, dcache_addr, dcache_wdata, mem_rdata;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic        mem_enable, mem_wr, ifill_we, dfill_we, idone, ddone, busy;
  logic [2:0]  fill_word;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .dcache_req(dcache_req), .dcache_addr(dcache_addr),
    .dcache_wr(dcache_wr), .dcache_wdata(dcache_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .fill_data(fill_data), .fill_word(fill_word),
    .ifill_we(ifill_we), .dfill_we(dfill_we),
    .idone(idone), .ddone(ddone), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
  } resp_t;

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_first;
    int          exp_done;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mem_lat = 4;
  bit          mem_silent = 1'b0;
  int          force_cnt = 0;
  logic [15:0] force_base = 16'h0;
  bit          rst_release = 1'b0;
  bit          model_last_d = 1'b0;
  string       cur_tag = "init";

  resp_t       resp_q[$];
  int          rd_cyc[$];
  logic [15:0] rd_addr[$];
  int          wr_cyc[$];
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  bit          fill_tgt[$];
  int          fill_w[$];
  logic [15:0] fill_dat[$];
  bit          done_d[$];
  int          done_cyc[$];

  // Contents of the behavioural memory: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // Concatenation of every DUT output, used for the all-zero checks.
  function automatic logic [63:0] all_outputs();
    return {6'd0, mem_addr, mem_enable, mem_wr, mem_wdata, fill_data,
            fill_word, ifill_we, dfill_we, idone, ddone, busy};
  endfunction

  // Compares one observed value with its required value and counts the result.
  task automatic checkOutput(input string name, input logic [63:0] act_v,
                             input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s/%s: got 0x%0h required 0x%0h", cur_tag, name, act_v, exp_v);
    end
  endtask

  // Empties all of the observation logs.
  task automatic clear_logs();
    rd_cyc.delete();  rd_addr.delete();
    wr_cyc.delete();  wr_addr.delete();  wr_data.delete();
    fill_tgt.delete(); fill_w.delete();  fill_dat.delete();
    done_d.delete();  done_cyc.delete();
  endtask

  // Runs one clock cycle.
  // At the negedge it drives the memory response; 1 time unit later it records the DUT outputs.
  // A requester drops its req in the same cycle that its done pulse is high.
  task automatic cycle();
    resp_t r;
    @(negedge clk);
    cyc++;
    if (rst_release) begin
      rst = 1'b0;
      rst_release = 1'b0;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0;
    if (force_cnt > 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = force_base;
      force_base = force_base + 16'd1;
      force_cnt--;
    end else if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = resp_q[0].data;
      void'(resp_q.pop_front());
    end
    #1;
    if (mem_enable === 1'b1 && mem_wr === 1'b0) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(mem_addr);
      if (!mem_silent) begin
        r.due  = cyc + mem_lat;
        r.data = mem_word(mem_addr);
        resp_q.push_back(r);
      end
    end
    if (mem_enable === 1'b1 && mem_wr === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (ifill_we === 1'b1 || dfill_we === 1'b1) begin
      fill_tgt.push_back(dfill_we);
      fill_w.push_back(int'(fill_word));
      fill_dat.push_back(fill_data);
    end
    if (idone === 1'b1 || ddone === 1'b1) begin
      done_d.push_back(ddone);
      done_cyc.push_back(cyc);
    end
    if (idone === 1'b1) icache_req = 1'b0;
    if (ddone === 1'b1) dcache_req = 1'b0;
  endtask

  // Raises one request and runs cycles until its done pulse is seen (bounded), then runs two idle cycles.
  task automatic applyStimulus(input bit is_d, input bit wr, input logic [15:0] addr,
                               input logic [15:0] wdata, output int start);
    clear_logs();
    resp_q.delete();
    if (is_d) begin
      dcache_req = 1'b1; dcache_wr = wr; dcache_addr = addr; dcache_wdata = wdata;
    end else begin
      icache_req = 1'b1; icache_addr = addr;
    end
    start = cyc;
    for (int n = 0; n < 60 && done_d.size() == 0; n++) cycle();
    repeat (2) cycle();
  endtask

  // Checks a single transaction against what it must produce: the addresses, the data, the fill targets and the done timing.
  task automatic verify_txn(input bit is_d, input bit wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input int start,
                            input logic [15:0] exp_first, input int exp_done);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    if (wr) begin
      checkOutput("wr_count", wr_addr.size(), 1);
      checkOutput("rd_count", rd_addr.size(), 0);
      checkOutput("fill_count", fill_w.size(), 0);
      if (wr_addr.size() > 0) begin
        checkOutput("wr_addr", wr_addr[0], exp_first);
        checkOutput("wr_data", wr_data[0], wdata);
        checkOutput("wr_cycle", wr_cyc[0] - start, 1);
      end
    end else begin
      checkOutput("rd_count", rd_addr.size(), 8);
      checkOutput("fill_count", fill_w.size(), 8);
      checkOutput("wr_count", wr_addr.size(), 0);
      if (rd_addr.size() > 0) checkOutput("first_addr", rd_addr[0], exp_first);
      for (int k = 0; k < 8 && k < rd_addr.size(); k++) begin
        checkOutput($sformatf("rd_addr%0d", k), rd_addr[k], base + 16'(2 * k));
        checkOutput($sformatf("rd_cycle%0d", k), rd_cyc[k] - start, k + 1);
      end
      for (int k = 0; k < 8 && k < fill_w.size(); k++) begin
        checkOutput($sformatf("fill_tgt%0d", k), fill_tgt[k], is_d);
        checkOutput($sformatf("fill_word%0d", k), fill_w[k], k);
        checkOutput($sformatf("fill_data%0d", k), fill_dat[k], mem_word(base + 16'(2 * k)));
      end
    end
    checkOutput("done_count", done_d.size(), 1);
    if (done_d.size() > 0) begin
      checkOutput("done_owner", done_d[0], is_d);
      checkOutput("done_cycle", done_cyc[0] - start, exp_done);
    end
    checkOutput("busy_after", busy, 1'b0);
    model_last_d = is_d;
  endtask

  // Raises both requests together and checks which owner is served first and which second.
  task automatic contested_round(input string tag);
    bit exp_first_d;
    cur_tag = tag;
    clear_logs();
    resp_q.delete();
    mem_lat = 4;
`ifdef ARB_ROUND_ROBIN_EN
    exp_first_d = !model_last_d;
`else
    exp_first_d = 1'b1;
`endif
    dcache_req = 1'b1; dcache_wr = 1'b0; dcache_addr = 16'h2000;
    icache_req = 1'b1; icache_addr = 16'h1236;
    for (int n = 0; n < 120 && done_d.size() < 2; n++) cycle();
    repeat (2) cycle();
    checkOutput("done_count", done_d.size(), 2);
    if (done_d.size() == 2) begin
      checkOutput("first_owner", done_d[0], exp_first_d);
      checkOutput("second_owner", done_d[1], !exp_first_d);
    end
    checkOutput("rd_count", rd_addr.size(), 16);
    if (rd_addr.size() == 16) begin
      checkOutput("first_block", rd_addr[0], exp_first_d ? 16'h2000 : 16'h1230);
      checkOutput("second_block", rd_addr[8], exp_first_d ? 16'h1230 : 16'h2000);
    end
    if (fill_tgt.size() == 16) begin
      checkOutput("first_fill_tgt", fill_tgt[7], exp_first_d);
      checkOutput("second_fill_tgt", fill_tgt[8], !exp_first_d);
    end
    checkOutput("busy_after", busy, 1'b0);
    model_last_d = !exp_first_d;
  endtask

  vec_t vecs[6];

  initial begin
    int start;
    vec_t v;
    bit r_is_d, r_wr;
    logic [15:0] r_addr, r_wdata;

    vecs[0] = '{1'b0, 1'b0, 16'h1236, 16'h0000, 16'h1230, 13};
    vecs[1] = '{1'b1, 1'b1, 16'h0041, 16'hBEEF, 16'h0040, 2};
    vecs[2] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 16'h2000, 13};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hFFF0, 13};
    vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'hFFFE, 2};
    vecs[5] = '{1'b1, 1'b0, 16'h000E, 16'h0000, 16'h0000, 13};

    rst = 1'b1;
    icache_req = 1'b1; dcache_req = 1'b1; dcache_wr = 1'b1;
    icache_addr = 16'h1111; dcache_addr = 16'h2222; dcache_wdata = 16'h3333;
    mem_rvalid = 1'b0; mem_rdata = 16'h0;

    // While reset is held, all outputs stay at 0 even with requests and read strobes active.
    cur_tag = "reset";
    force_cnt = 3; force_base = 16'hAAAA;
    repeat (3) cycle();
    checkOutput("outputs_in_reset", all_outputs(), 64'd0);
    icache_req = 1'b0; dcache_req = 1'b0; dcache_wr = 1'b0;
    rst_release = 1'b1;
    cycle();
    checkOutput("outputs_after_reset", all_outputs(), 64'd0);
    model_last_d = 1'b0;

    // Table-driven single transactions, using a fixed 4-cycle memory.
    mem_lat = 4;
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      cur_tag = $sformatf("vec%0d", i);
      applyStimulus(v.is_d, v.wr, v.addr, v.wdata, start);
      verify_txn(v.is_d, v.wr, v.addr, v.wdata, start, v.exp_first, v.exp_done);
    end

    contested_round("contest_a");
    contested_round("contest_b");

    // Reset during the 4th ISSUE cycle of an I fill: no done pulse, and late or stray strobes are ignored.
    cur_tag = "reset_abort";
    clear_logs(); resp_q.delete(); mem_lat = 4;
    icache_req = 1'b1; icache_addr = 16'h1236;
    repeat (4) cycle();
    checkOutput("issued_before_reset", rd_addr.size(), 4);
    rst = 1'b1; icache_req = 1'b0; rst_release = 1'b1;
    cycle();
    checkOutput("outputs_after_abort", all_outputs(), 64'd0);
    clear_logs();
    repeat (4) cycle();
    force_cnt = 4; force_base = 16'h7000;
    repeat (5) cycle();
    checkOutput("stray_fills", fill_w.size(), 0);
    checkOutput("stray_done", done_d.size(), 0);
    checkOutput("stray_reads", rd_addr.size(), 0);
    checkOutput("busy_after", busy, 1'b0);
    model_last_d = 1'b0;

    contested_round("contest_after_reset");

    // mem_rvalid held high for 10 cycles during a D fill: exactly 8 words are taken.
    cur_tag = "rvalid_hold";
    clear_logs(); resp_q.delete(); mem_silent = 1'b1;
    dcache_req = 1'b1; dcache_wr = 1'b0; dcache_addr = 16'h3004;
    start = cyc; force_cnt = 10; force_base = 16'h5000;
    repeat (12) cycle();
    mem_silent = 1'b0;
    checkOutput("fill_count", fill_w.size(), 8);
    for (int k = 0; k < 8 && k < fill_w.size(); k++) begin
      checkOutput($sformatf("fill_tgt%0d", k), fill_tgt[k], 1'b1);
      checkOutput($sformatf("fill_word%0d", k), fill_w[k], k);
      checkOutput($sformatf("fill_data%0d", k), fill_dat[k], 16'h5000 + 16'(k));
    end
    checkOutput("rd_count", rd_addr.size(), 8);
    checkOutput("done_count", done_d.size(), 1);
    if (done_d.size() > 0) begin
      checkOutput("done_owner", done_d[0], 1'b1);
      checkOutput("done_cycle", done_cyc[0] - start, 9);
    end
    checkOutput("busy_after", busy, 1'b0);
    model_last_d = 1'b1;

    // Random single transactions with a random memory latency.
    for (int r = 0; r < 25; r++) begin
      cur_tag = $sformatf("rand%0d", r);
      r_is_d  = 1'($urandom_range(0, 1));
      r_wr    = r_is_d && ($urandom_range(0, 1) == 1);
      r_addr  = 16'($urandom);
      r_wdata = 16'($urandom);
      mem_lat = int'($urandom_range(1, 6));
      applyStimulus(r_is_d, r_wr, r_addr, r_wdata, start);
      verify_txn(r_is_d, r_wr, r_addr, r_wdata, start,
                 r_wr ? (r_addr & 16'hFFFE) : (r_addr & 16'hFFF0),
                 r_wr ? 2 : 9 + mem_lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Stops a run that hangs. It reports the hang as a failure instead of running forever.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
